char_uart_tx: RTL and testbench
===============================

# char_uart_tx

Downstream output stage for the experiment-number-six character source. It accepts 8-bit characters over a valid/ready handshake and buffers them in a small FIFO. It serializes each character onto a single 8N1 UART line (LSB first) and reports a wrapping count of characters fully transmitted. The upstream message generator (the one that exposes `chars_remaining`) feeds `char_in` directly. `tx` drives a dedicated output pin.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; legal range 1..65535.
- `FIFO_DEPTH`, 4: character buffer depth; power of two, 2..16.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `char_in`  in  8  character from the upstream message source.
- `char_valid`  in  1  `char_in` holds a character to enqueue.
- `char_ready`  out  1  FIFO can accept a character this cycle.
- `tx`  out  1  UART serial output; idles high.
- `busy`  out  1  FIFO non-empty, or a frame in progress.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of characters currently buffered.
- `chars_sent`  out  8  count of completed frames, wraps 255→0.

## Operation
- Reset values: `tx`=1, `char_ready`=0 while `rst` is high, `busy`=0, `fifo_level`=0, `chars_sent`=0, FSM=IDLE. The FIFO pointers and bit/baud counters are cleared.
- `char_ready` = !`rst` && (`fifo_level` != FIFO_DEPTH). It is combinational from registered level only; a pop in the same cycle does not free a slot early.
- Push: on a clock edge where `char_valid` && `char_ready`, write `char_in` at the write pointer and increment it. Pointers wrap modulo FIFO_DEPTH.
- Pop: performed by the FSM, as described below.
- Push and pop on the same edge: `fifo_level` is unchanged and both pointers advance.
- `char_valid` while full: ignored, no overwrite. The upstream stage must hold the character until `char_ready` is high.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If `fifo_level`>0, pop the head into the shift register, clear the baud counter and bit index, and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After 8 bits, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On the final cycle, increment `chars_sent` (mod 256). If `fifo_level`>0, pop and go directly to START; otherwise go to IDLE.
- `tx` is driven from a register, so it is glitch-free.
- `busy` = (FSM != IDLE) || (`fifo_level` != 0).
- Reset mid-frame: on the edge where `rst` is sampled high, `tx` returns to 1, the frame is abandoned, buffered characters are discarded, and `chars_sent` is not incremented.

## Timing
- Accept-to-start latency is 1 cycle. For a character accepted at edge k into an idle block:
  - edge k+1 pops it and enters START;
  - `tx` is 0 from edge k+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles: start, 8 data bits, stop.
- Back-to-back frames have zero idle cycles. The next start bit begins on the edge immediately after the last stop-bit cycle.
- `chars_sent` updates on the same edge on which the stop bit ends.
- `fifo_level` reflects a push or pop one edge after the handshake or pop occurs.
- Throughput: one character per 10×CLKS_PER_BIT cycles. The FIFO absorbs bursts of up to FIFO_DEPTH characters, plus the one being shifted.

## Test plan
Unless stated otherwise, benches use CLKS_PER_BIT=4 and FIFO_DEPTH=4.

- Single character 0x55 after reset → `tx` goes low 1 cycle after accept and holds each of the bits 0,1,0,1,0,1,0,1,0,1 for 4 cycles (40 cycles total). `chars_sent`=1 and `busy` falls on the same edge.
- Back-to-back 'H' (0x48) then 'i' (0x69), pushed on consecutive cycles → 80 contiguous frame cycles with no high gap between the stop bit and the next start. Decoded bytes are 0x48, 0x69; `chars_sent`=2.
- Burst of 6 characters with `char_valid` held high → characters 1..5 accepted, since the first is popped after 1 cycle and the FIFO then fills with 4. `char_ready` stays low until the first frame's stop bit ends. All 6 bytes appear on `tx` in order.
- Push and pop on the same edge (FIFO at level 1, push on the final stop cycle) → `fifo_level` stays 1 and no character is lost or duplicated.
- Reset asserted for 1 cycle during bit 3 of a frame, with 2 characters queued → `tx`=1, `fifo_level`=0, `chars_sent`=0, `busy`=0, and `char_ready`=0 during reset. A fresh push afterwards transmits normally.
- With CLKS_PER_BIT=1, send 257 characters → `chars_sent` wraps through 255 to 0 and then reads 1.

Source files
------------

// File: rtl/char_uart_tx.sv
// rtl/char_uart_tx.sv - FIFO-buffered 8N1 UART transmitter for a character stream
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   char_in     character to enqueue
//   char_valid  char_in holds a character
//   char_ready  FIFO has a free slot (low while rst is high)
//   tx          registered UART line, idles high, LSB first
//   busy        FIFO non-empty or a frame in progress
//   fifo_level  characters currently buffered
//   chars_sent  completed frames, wraps 255 -> 0
module char_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    char_in,
  input  logic                          char_valid,
  output logic                          char_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    chars_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [7:0]      sent_q;
  logic            sent_inc;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic            push, pop;
  logic            baud_last;

  // Ready looks only at the registered level, so a pop on this edge does
  // not open a slot until the next cycle.
  assign char_ready = !rst && (level_q != FULL_LEVEL);
  assign push       = char_valid && char_ready;
  assign baud_last  = (baud_q == BAUD_LAST);

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (level_q != '0);
  assign fifo_level = level_q;
  assign chars_sent = sent_q;

  // tx_d is the line value for the cycle after this edge, so tx stays a
  // plain register output with no decode glitches.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    sent_inc = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (level_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d   = '0;
          sent_inc = 1'b1;
          // Chain straight into the next start bit when data is waiting.
          if (level_q != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            bit_d   = '0;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      sent_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      if (sent_inc) sent_q <= sent_q + 8'd1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= char_in;
  end

endmodule

// File: tb/tb_char_uart_tx.sv
// tb/tb_char_uart_tx.sv - directed self-checking bench for char_uart_tx
module tb_char_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst1;
  logic [7:0] char_in, char_in1;
  logic       char_valid, char_valid1;
  logic       char_ready, char_ready1;
  logic       tx, tx1;
  logic       busy, busy1;
  logic [2:0] fifo_level, fifo_level1;
  logic [7:0] chars_sent, chars_sent1;

  int asserts  = 0;
  int failures = 0;

  logic [7:0]  burst_chars [6];
  logic [39:0] burst_got [6];
  int          acc_edge [6];

  char_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .tx(tx), .busy(busy),
    .fifo_level(fifo_level), .chars_sent(chars_sent)
  );

  char_uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst1), .char_in(char_in1), .char_valid(char_valid1),
    .char_ready(char_ready1), .tx(tx1), .busy(busy1),
    .fifo_level(fifo_level1), .chars_sent(chars_sent1)
  );

  // Expected line waveform for one frame at 4 clocks per bit, cycle 0 first.
  function automatic logic [39:0] frame_wave(input logic [7:0] b);
    logic [9:0]  bits;
    logic [39:0] w;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) w[i] = bits[i/4];
    return w;
  endfunction

  // Records tx for 40 cycles, starting at the current negedge.
  task automatic capture_frame(output logic [39:0] w);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      w[i] = tx;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    char_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst1 = 1'b1;
    char_valid = 1'b0; char_valid1 = 1'b0;
    char_in = 8'h00; char_in1 = 8'h00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    asserts++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
    asserts++; if (char_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", char_ready); end
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    asserts++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    asserts++; if (chars_sent !== 8'd0) begin failures++; $display("FAIL reset_sent: got %0d expected 0", chars_sent); end
    asserts++; if (chars_sent1 !== 8'd0) begin failures++; $display("FAIL reset_sent1: got %0d expected 0", chars_sent1); end
    rst = 1'b0; rst1 = 1'b0;
    #1;
    asserts++; if (char_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_release: got %b expected 1", char_ready); end
  endtask

  task automatic test_single();
    logic [39:0] got;
    do_reset();
    char_in = 8'h55; char_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    asserts++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL single_level: got %0d expected 1", fifo_level); end
    asserts++; if (tx !== 1'b1) begin failures++; $display("FAIL single_tx_accept: got %b expected 1", tx); end
    @(posedge clk);
    @(negedge clk);
    capture_frame(got);
    asserts++; if (got !== frame_wave(8'h55)) begin failures++; $display("FAIL single_wave: got %h expected %h", got, frame_wave(8'h55)); end
    asserts++; if (chars_sent !== 8'd0 || busy !== 1'b1) begin failures++; $display("FAIL single_before_end: sent %0d busy %b expected 0 1", chars_sent, busy); end
    @(posedge clk);
    @(negedge clk);
    asserts++; if (chars_sent !== 8'd1) begin failures++; $display("FAIL single_sent: got %0d expected 1", chars_sent); end
    asserts++; if (busy !== 1'b0 || tx !== 1'b1) begin failures++; $display("FAIL single_idle: busy %b tx %b expected 0 1", busy, tx); end
  endtask

  task automatic test_back_to_back();
    logic [39:0] g1, g2;
    do_reset();
    char_in = 8'h48; char_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    char_in = 8'h69;
    asserts++; if (char_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b expected 1", char_ready); end
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    asserts++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL b2b_level: got %0d expected 1", fifo_level); end
    capture_frame(g1);
    @(posedge clk);
    @(negedge clk);
    capture_frame(g2);
    asserts++; if (g1 !== frame_wave(8'h48)) begin failures++; $display("FAIL b2b_frame_h: got %h expected %h", g1, frame_wave(8'h48)); end
    asserts++; if (g2 !== frame_wave(8'h69)) begin failures++; $display("FAIL b2b_frame_i: got %h expected %h", g2, frame_wave(8'h69)); end
    @(posedge clk);
    @(negedge clk);
    asserts++; if (chars_sent !== 8'd2 || busy !== 1'b0) begin failures++; $display("FAIL b2b_sent: sent %0d busy %b expected 2 0", chars_sent, busy); end
  endtask

  task automatic test_burst();
    int   idx, cyc;
    logic rdy;
    burst_chars[0] = 8'hA5; burst_chars[1] = 8'h3C; burst_chars[2] = 8'h00;
    burst_chars[3] = 8'hFF; burst_chars[4] = 8'h81; burst_chars[5] = 8'h7E;
    for (int i = 0; i < 6; i++) acc_edge[i] = -1;
    do_reset();
    idx = 0; cyc = 0;
    char_in = burst_chars[0]; char_valid = 1'b1;
    fork
      begin
        while (idx < 6 && cyc < 200) begin
          rdy = char_ready;
          @(posedge clk);
          @(negedge clk);
          if (cyc == 4) begin
            asserts++; if (fifo_level !== 3'd4 || char_ready !== 1'b0) begin failures++; $display("FAIL burst_full: level %0d ready %b expected 4 0", fifo_level, char_ready); end
          end
          if (cyc == 40) begin
            asserts++; if (char_ready !== 1'b0) begin failures++; $display("FAIL burst_ready_last_stop: got %b expected 0", char_ready); end
          end
          if (cyc == 41) begin
            asserts++; if (char_ready !== 1'b1) begin failures++; $display("FAIL burst_ready_after_stop: got %b expected 1", char_ready); end
          end
          if (rdy) begin
            acc_edge[idx] = cyc;
            idx++;
            if (idx < 6) char_in = burst_chars[idx];
            else char_valid = 1'b0;
          end
          cyc++;
        end
        char_valid = 1'b0;
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        for (int f = 0; f < 6; f++) begin
          if (f > 0) begin
            @(posedge clk);
            @(negedge clk);
          end
          capture_frame(burst_got[f]);
        end
      end
    join
    asserts++; if (idx !== 6) begin failures++; $display("FAIL burst_accepted: got %0d expected 6", idx); end
    asserts++; if (acc_edge[4] !== 4) begin failures++; $display("FAIL burst_fifth_accept: got %0d expected 4", acc_edge[4]); end
    asserts++; if (acc_edge[5] !== 42) begin failures++; $display("FAIL burst_sixth_accept: got %0d expected 42", acc_edge[5]); end
    for (int f = 0; f < 6; f++) begin
      asserts++;
      if (burst_got[f] !== frame_wave(burst_chars[f])) begin
        failures++;
        $display("FAIL burst_frame%0d: got %h expected %h", f, burst_got[f], frame_wave(burst_chars[f]));
      end
    end
    @(posedge clk);
    @(negedge clk);
    asserts++; if (chars_sent !== 8'd6 || busy !== 1'b0) begin failures++; $display("FAIL burst_sent: sent %0d busy %b expected 6 0", chars_sent, busy); end
  endtask

  task automatic test_push_pop_same_edge();
    logic [39:0] ga, gb, gc;
    do_reset();
    char_in = 8'h4F; char_valid = 1'b1;
    fork
      begin
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        char_in = 8'h4B; char_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        repeat (38) @(posedge clk);
        @(negedge clk);
        asserts++; if (fifo_level !== 3'd1 || char_ready !== 1'b1) begin failures++; $display("FAIL same_edge_pre: level %0d ready %b expected 1 1", fifo_level, char_ready); end
        char_in = 8'h21; char_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        asserts++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL same_edge_level: got %0d expected 1", fifo_level); end
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        capture_frame(ga);
        @(posedge clk);
        @(negedge clk);
        capture_frame(gb);
        @(posedge clk);
        @(negedge clk);
        capture_frame(gc);
      end
    join
    asserts++; if (ga !== frame_wave(8'h4F)) begin failures++; $display("FAIL same_edge_frame_a: got %h expected %h", ga, frame_wave(8'h4F)); end
    asserts++; if (gb !== frame_wave(8'h4B)) begin failures++; $display("FAIL same_edge_frame_b: got %h expected %h", gb, frame_wave(8'h4B)); end
    asserts++; if (gc !== frame_wave(8'h21)) begin failures++; $display("FAIL same_edge_frame_c: got %h expected %h", gc, frame_wave(8'h21)); end
    @(posedge clk);
    @(negedge clk);
    asserts++; if (chars_sent !== 8'd3 || busy !== 1'b0) begin failures++; $display("FAIL same_edge_sent: sent %0d busy %b expected 3 0", chars_sent, busy); end
  endtask

  task automatic test_reset_mid_frame();
    logic [39:0] got;
    do_reset();
    char_in = 8'hC3; char_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    char_in = 8'h11;
    @(posedge clk);
    @(negedge clk);
    char_in = 8'h22;
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    asserts++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL midrst_queued: got %0d expected 2", fifo_level); end
    repeat (16) @(posedge clk);
    @(negedge clk);
    asserts++; if (tx !== 1'b0) begin failures++; $display("FAIL midrst_bit3: got %b expected 0", tx); end
    rst = 1'b1;
    #1;
    asserts++; if (char_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready_during: got %b expected 0", char_ready); end
    @(posedge clk);
    @(negedge clk);
    asserts++; if (tx !== 1'b1 || fifo_level !== 3'd0) begin failures++; $display("FAIL midrst_state: tx %b level %0d expected 1 0", tx, fifo_level); end
    asserts++; if (chars_sent !== 8'd0 || busy !== 1'b0 || char_ready !== 1'b0) begin failures++; $display("FAIL midrst_flags: sent %0d busy %b ready %b expected 0 0 0", chars_sent, busy, char_ready); end
    rst = 1'b0;
    char_in = 8'h5A; char_valid = 1'b1;
    #1;
    asserts++; if (char_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready_after: got %b expected 1", char_ready); end
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    capture_frame(got);
    asserts++; if (got !== frame_wave(8'h5A)) begin failures++; $display("FAIL midrst_fresh_frame: got %h expected %h", got, frame_wave(8'h5A)); end
    @(posedge clk);
    @(negedge clk);
    asserts++; if (chars_sent !== 8'd1) begin failures++; $display("FAIL midrst_fresh_sent: got %0d expected 1", chars_sent); end
  endtask

  task automatic test_wrap();
    int         pushed, cyc, steps, bad;
    logic       rdy, saw_wrap;
    logic [7:0] prev;
    @(negedge clk);
    rst1 = 1'b1; char_valid1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    pushed = 0; cyc = 0; steps = 0; bad = 0; saw_wrap = 1'b0; prev = 8'd0;
    char_in1 = 8'd0; char_valid1 = 1'b1;
    while (!(pushed == 257 && !busy1) && cyc < 6000) begin
      rdy = char_ready1 && char_valid1;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (rdy) begin
        pushed++;
        char_in1 = 8'(pushed);
        if (pushed == 257) char_valid1 = 1'b0;
      end
      if (chars_sent1 !== prev) begin
        if (chars_sent1 !== 8'(prev + 8'd1)) bad++;
        if (prev == 8'd255 && chars_sent1 == 8'd0) saw_wrap = 1'b1;
        prev = chars_sent1;
        steps++;
      end
    end
    asserts++; if (cyc >= 6000) begin failures++; $display("FAIL wrap_timeout: cycles %0d limit 6000", cyc); end
    asserts++; if (steps !== 257) begin failures++; $display("FAIL wrap_steps: got %0d expected 257", steps); end
    asserts++; if (bad !== 0) begin failures++; $display("FAIL wrap_increment: got %0d bad steps expected 0", bad); end
    asserts++; if (saw_wrap !== 1'b1) begin failures++; $display("FAIL wrap_255_to_0: got %b expected 1", saw_wrap); end
    asserts++; if (chars_sent1 !== 8'd1) begin failures++; $display("FAIL wrap_final: got %0d expected 1", chars_sent1); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded 2000000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_burst();
    test_push_pop_same_edge();
    test_reset_mid_frame();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
